alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Initiator side of the ALU operand interface: accepts one operation request over a valid/ready port and drives
//  opcode/a/b/enable into the non-pipelined ALU. Holds operands stable for ALU_LAT cycles, then captures the
//  ALU result and returns it over a valid/ready response port. Sits between the issue/register-read stage and the ALU.
//  Rejects unimplemented opcodes with an error response and never presents them to the ALU.
// PARAMETERS
//  WIDTH    32  operand/result width
//  OPW      5   opcode width
//  ALU_LAT  2   cycles alu_enable/operands are held before alu_out is sampled (legal range 1..15)
//  NUM_OPS  16  opcodes 0..NUM_OPS-1 are legal; NUM_OPS..2**OPW-1 are rejected
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous reset, active low
//  req_valid   in   1      request present
//  req_ready   out  1      controller can accept a request
//  req_opcode  in   OPW    operation code
//  req_a       in   WIDTH  operand a
//  req_b       in   WIDTH  operand b
//  alu_opcode  out  OPW    opcode to ALU
//  alu_a       out  WIDTH  operand a to ALU
//  alu_b       out  WIDTH  operand b to ALU
//  alu_enable  out  1      ALU enable
//  alu_out     in   WIDTH  ALU result
//  rsp_valid   out  1      response present
//  rsp_ready   in   1      consumer accepts response
//  rsp_data    out  WIDTH  captured result (0 on error)
//  rsp_err     out  1      request had an illegal opcode
//  op_count    out  16     completed legal operations, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; req_ready=0 while in reset; alu_enable=0; alu_opcode/alu_a/alu_b=0;
//    rsp_valid=0; rsp_data=0; rsp_err=0; op_count=0; latency counter=0. Reset mid-operation discards the operation.
//  - All outputs are registered; alu_* change only at clock edges.
//  - FSM states IDLE, BUSY, RESP:
//  - IDLE: req_ready=1. On req_valid&req_ready at edge E0: latch opcode/a/b.
//    Legal opcode -> BUSY: alu_enable=1, alu_* = latched values from E0, counter=ALU_LAT-1.
//    Illegal opcode (>=NUM_OPS) -> RESP: rsp_valid=1, rsp_err=1, rsp_data=0; alu_enable stays 0.
//  - BUSY: req_ready=0. alu_opcode/alu_a/alu_b held constant. Counter decrements each edge.
//    At the edge where counter==0 (E0+ALU_LAT): rsp_data<=alu_out, rsp_err<=0, rsp_valid<=1,
//    alu_enable<=0, alu_a/alu_b/alu_opcode<=0, op_count<=op_count+1, -> RESP.
//  - RESP: req_ready=0. rsp_valid/rsp_data/rsp_err held stable until rsp_ready=1 at an edge;
//    then rsp_valid<=0 and -> IDLE. Throughput one op per ALU_LAT+2 cycles minimum.
//  - req_valid is ignored outside IDLE; requester holds it until req_ready handshake.
//  - Never alu_enable=1 with rsp_valid=1; never more than one operation in flight.
//  - rsp_ready asserted while rsp_valid=0 has no effect.
//  - op_count counts only legal operations, at capture time, independent of response acceptance.
// TESTING
//  1 Reset: rst_n=0 async mid-cycle -> all outputs 0 immediately; release -> req_ready=1 next edge.
//  2 AND op=8, a=F0F0F0F0, b=FF00FF00, ALU_LAT=2 -> alu_enable high exactly 2 cycles,
//    rsp_valid rises at E0+2, rsp_data=F000F000, rsp_err=0, op_count=1.
//  3 Illegal op=20, a=1, b=2 -> alu_enable never asserted, rsp_valid at E0+1, rsp_err=1, rsp_data=0, op_count unchanged.
//  4 Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req_ready=0, new req_valid ignored;
//    rsp_ready=1 -> IDLE next edge, queued request then accepted.
//  5 rst_n pulsed low in BUSY (op=9) -> alu_enable=0, rsp_valid=0, op_count=0; no response ever produced.
//  6 100 back-to-back legal ops with rsp_ready=1 -> 100 responses, in order, each ALU_LAT+2 cycles apart; op_count=100.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue-side controller for a non-pipelined ALU: accepts one request, holds operands
// for ALU_LAT cycles, captures the result and returns it over a valid/ready response port.
module alu_issue_ctrl #(
   parameter int WIDTH   = 32,
   parameter int OPW     = 5,
   parameter int ALU_LAT = 2,
   parameter int NUM_OPS = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [OPW-1:0]   req_opcode,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [OPW-1:0]   alu_opcode,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_enable,
   input  logic [WIDTH-1:0] alu_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
   output logic [15:0]      op_count
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   // One extra bit so NUM_OPS == 2**OPW (every opcode legal) still fits.
   localparam logic [OPW:0] NUM_OPS_W = (OPW+1)'(NUM_OPS);
   localparam logic [3:0]   LAT_M1    = 4'(ALU_LAT - 1);

   state_t           state_q, state_d;
   logic             req_ready_q, req_ready_d;
   logic [OPW-1:0]   alu_opcode_q, alu_opcode_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic             alu_enable_q, alu_enable_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_err_q, rsp_err_d;
   logic [15:0]      op_count_q, op_count_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             op_legal;

   assign op_legal = ({1'b0, req_opcode} < NUM_OPS_W);

   always_comb begin
      state_d      = state_q;
      req_ready_d  = req_ready_q;
      alu_opcode_d = alu_opcode_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_enable_d = alu_enable_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;
      op_count_d   = op_count_q;
      cnt_d        = cnt_q;
      unique case (state_q)
         IDLE: begin
            // req_ready_q is still low on the first cycle out of reset.
            if (req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               if (op_legal) begin
                  state_d      = BUSY;
                  alu_enable_d = 1'b1;
                  alu_opcode_d = req_opcode;
                  alu_a_d      = req_a;
                  alu_b_d      = req_b;
                  cnt_d        = LAT_M1;
               end else begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_data_d  = '0;
               end
            end else begin
               req_ready_d = 1'b1;
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) begin
               state_d      = RESP;
               rsp_data_d   = alu_out;
               rsp_err_d    = 1'b0;
               rsp_valid_d  = 1'b1;
               alu_enable_d = 1'b0;
               alu_opcode_d = '0;
               alu_a_d      = '0;
               alu_b_d      = '0;
               op_count_d   = op_count_q + 16'd1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b0;
         alu_opcode_q <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_enable_q <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         op_count_q   <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         alu_opcode_q <= alu_opcode_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_enable_q <= alu_enable_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
         op_count_q   <= op_count_d;
         cnt_q        <= cnt_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign alu_opcode = alu_opcode_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_enable = alu_enable_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_err    = rsp_err_q;
   assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: combinational ALU stand-in, timestamp-based reference model
// compared every cycle, plus directed literal checks and a randomized phase.
module tb_alu_issue_ctrl;
   localparam int W = 32, OPW = 5, L = 2, NOPS = 16;

   logic clk = 1'b0, rst_n = 1'b0;
   logic req_valid = 1'b0, req_ready;
   logic [OPW-1:0] req_opcode = '0, alu_opcode;
   logic [W-1:0] req_a = '0, req_b = '0, alu_a, alu_b, alu_out, rsp_data;
   logic alu_enable, rsp_valid, rsp_ready = 1'b1, rsp_err;
   logic [15:0] op_count;

   int n_chk = 0, n_fail = 0;
   bit chk_on = 0, log_on = 0, rnd_rr = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.WIDTH(W), .OPW(OPW), .ALU_LAT(L), .NUM_OPS(NOPS)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_enable(alu_enable),
      .alu_out(alu_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .op_count(op_count));

   function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (op)
         5'd0:  r = a + b;
         5'd1:  r = a - b;
         5'd2:  r = a ^ b;
         5'd3:  r = a | b;
         5'd4:  r = a << b[4:0];
         5'd5:  r = a >> b[4:0];
         5'd6:  r = {31'b0, a < b};
         5'd7:  r = a * b;
         5'd8:  r = a & b;
         5'd9:  r = ~(a | b);
         5'd10: r = a;
         5'd11: r = b;
         5'd12: r = ~a;
         5'd13: r = a + 32'd1;
         5'd14: r = b - a;
         5'd15: r = {31'b0, a == b};
         default: r = '0;
      endcase
      return r;
   endfunction

   assign alu_out = alu_fn(alu_opcode, alu_a, alu_b);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: one op at a time, described by its accept edge and the edge its result appears.
   int cyc = 0, acc = -1;
   bit m_rdy, m_rv, m_err;
   logic [4:0] m_op;
   logic [31:0] m_a, m_b, m_data;
   logic [15:0] m_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rdy = 0; acc = -1; m_op = 0; m_a = 0; m_b = 0;
         m_rv = 0; m_err = 0; m_data = 0; m_cnt = 0;
      end else begin
         cyc++;
         if (m_rv) begin
            if (rsp_ready) begin m_rv = 0; m_rdy = 1; end
         end else if (acc >= 0) begin
            if (cyc == acc + L) begin
               m_rv = 1; m_err = 0; m_data = alu_fn(m_op, m_a, m_b);
               m_cnt = m_cnt + 16'd1; acc = -1;
            end
         end else if (m_rdy && req_valid) begin
            m_rdy = 0;
            if (int'(req_opcode) >= NOPS) begin
               m_rv = 1; m_err = 1; m_data = 0;
            end else begin
               acc = cyc; m_op = req_opcode; m_a = req_a; m_b = req_b;
            end
         end else begin
            m_rdy = 1;
         end
      end
   end

   int ncyc = 0;
   bit prev_rv = 0;
   int rise_t[$];
   logic [31:0] exp_q[$];
   always @(negedge clk) begin
      ncyc++;
      if (chk_on) begin
         chk("req_ready", req_ready, m_rdy);
         chk("alu_enable", alu_enable, acc >= 0);
         chk("alu_opcode", alu_opcode, (acc >= 0) ? m_op : 5'd0);
         chk("alu_a", alu_a, (acc >= 0) ? m_a : 32'd0);
         chk("alu_b", alu_b, (acc >= 0) ? m_b : 32'd0);
         chk("rsp_valid", rsp_valid, m_rv);
         chk("rsp_data", rsp_data, m_data);
         chk("rsp_err", rsp_err, m_err);
         chk("op_count", op_count, m_cnt);
         if (alu_enable && rsp_valid) chk("en_and_rv", 1, 0);
      end
      if (log_on && rsp_valid && !prev_rv) begin
         rise_t.push_back(ncyc);
         if (exp_q.size() > 0) chk("order", rsp_data, exp_q.pop_front());
         else chk("extra_rsp", 1, 0);
      end
      prev_rv = rsp_valid;
   end

   always @(negedge clk) if (rnd_rr) begin #1; rsp_ready = 1'($urandom_range(0, 1)); end

   // Present a request from just after a falling edge; returns 1ns after the accepting edge.
   task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      int i = 0;
      @(negedge clk); #1;
      req_valid = 1; req_opcode = op; req_a = a; req_b = b;
      while (!req_ready && i < 500) begin @(negedge clk); #1; i++; end
      if (!req_ready) begin
         n_chk++; n_fail++;
         $display("FAIL send_timeout: got no req_ready expected handshake at %0t", $time);
      end else begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int en_n, rise, bad, n_legal;
      logic [31:0] dat, oc, er;
      bit seen;
      logic [4:0] op;
      logic [31:0] a, b;

      // Reset values
      #12;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_alu_enable", alu_enable, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_op_count", op_count, 0);
      chk_on = 1;
      @(negedge clk); #2 rst_n = 1;
      @(negedge clk);
      chk("rel_req_ready", req_ready, 1);

      // AND: enable for exactly L cycles, result L edges after accept
      send(5'd8, 32'hF0F0F0F0, 32'hFF00FF00);
      req_valid = 0;
      en_n = 0; rise = -1; dat = 0; oc = 0; er = 1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (alu_enable) en_n++;
         if (rsp_valid && rise < 0) begin rise = k; dat = rsp_data; oc = op_count; er = rsp_err; end
      end
      chk("and_en_cycles", en_n, 2);
      chk("and_rise", rise, 2);
      chk("and_data", dat, 32'hF000F000);
      chk("and_err", er, 0);
      chk("and_count", oc, 1);

      // Illegal opcode under back-pressure, with a queued request
      @(negedge clk); #1 rsp_ready = 0;
      send(5'd20, 32'd1, 32'd2);
      req_opcode = 5'd3; req_a = 32'd5; req_b = 32'd6;
      @(negedge clk);
      chk("ill_rsp_valid", rsp_valid, 1);
      chk("ill_rsp_err", rsp_err, 1);
      chk("ill_rsp_data", rsp_data, 0);
      chk("ill_alu_enable", alu_enable, 0);
      chk("ill_op_count", op_count, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_err", rsp_err, 1);
      end
      #1 rsp_ready = 1;
      send(5'd3, 32'd5, 32'd6);
      req_valid = 0;
      repeat (3) @(negedge clk);
      chk("q_rsp_valid", rsp_valid, 1);
      chk("q_rsp_data", rsp_data, 32'd7);
      chk("q_rsp_err", rsp_err, 0);
      chk("q_op_count", op_count, 2);

      // Reset in the middle of an operation
      send(5'd9, 32'h1234, 32'h4321);
      req_valid = 0;
      @(negedge clk); #2 rst_n = 0;
      #1;
      chk("mid_alu_enable", alu_enable, 0);
      chk("mid_alu_a", alu_a, 0);
      chk("mid_rsp_valid", rsp_valid, 0);
      chk("mid_op_count", op_count, 0);
      @(negedge clk); #2 rst_n = 1;
      seen = 0;
      repeat (10) begin @(negedge clk); if (rsp_valid) seen = 1; end
      chk("mid_no_rsp", seen, 0);
      chk("mid_count_after", op_count, 0);

      // 100 back-to-back legal ops
      rise_t.delete(); exp_q.delete(); log_on = 1;
      for (int i = 0; i < 100; i++) begin
         op = 5'($urandom_range(0, NOPS - 1)); a = $urandom; b = $urandom;
         exp_q.push_back(alu_fn(op, a, b));
         send(op, a, b);
      end
      req_valid = 0;
      repeat (L + 4) @(negedge clk);
      log_on = 0;
      chk("b2b_responses", rise_t.size(), 100);
      bad = 0;
      for (int i = 1; i < rise_t.size(); i++) if (rise_t[i] - rise_t[i-1] != L + 2) bad++;
      chk("b2b_bad_gaps", bad, 0);
      chk("b2b_op_count", op_count, 100);

      // Random mix of legal/illegal ops, idle gaps and response back-pressure
      n_legal = 0; rnd_rr = 1;
      for (int i = 0; i < 200; i++) begin
         req_valid = 0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(NOPS, 31)) : 5'($urandom_range(0, NOPS - 1));
         if (int'(op) < NOPS) n_legal++;
         send(op, $urandom, $urandom);
      end
      req_valid = 0;
      rnd_rr = 0;
      @(negedge clk); #1 rsp_ready = 1;
      repeat (10) @(negedge clk);
      chk("rnd_op_count", op_count, 100 + n_legal);
      chk("rnd_drained", rsp_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
